jtag_dtm_tap: RTL and testbench
===============================

JTAG_DTM_TAP -- requirements
Module: jtag_dtm_tap

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1e200a6d, value captured by the IDCODE DR.
REQ-002 SHALL have parameter DMI_ABITS, default 6, DMI address width; DMI DR width is DMI_ABITS+34.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 jtag_tck  input  1  JTAG clock pin, asynchronous to clk.
REQ-006 jtag_tms  input  1  JTAG mode select pin.
REQ-007 jtag_tdi  input  1  JTAG serial data in.
REQ-008 jtag_tdo  output  1  JTAG serial data out.
REQ-009 dmi_req_valid  output  1  DMI request pending.
REQ-010 dmi_req_ready  input  1  debug module accepts request.
REQ-011 dmi_req_data  output  DMI_ABITS+34  packed as {addr, data[31:0], op[1:0]}.
REQ-012 dmi_resp_valid  input  1  response data valid.
REQ-013 dmi_resp_data  input  32  read data from the debug module.

Function
REQ-014 jtag_tck, jtag_tms and jtag_tdi SHALL each pass through a 2-flop synchronizer on clk.
- A registered copy of synced TCK SHALL produce one-cycle rise and fall strobes.
- Pin-to-strobe latency is 3 clk.
- Supported TCK frequency is at most clk/8.
REQ-015 On each TCK rise strobe, the standard 16-state IEEE 1149.1 TAP FSM SHALL advance on synced TMS.
- States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, and the matching IR states.
REQ-016 Five consecutive rises with TMS=1 SHALL reach TLR from any state. In TLR, IR SHALL be 5'h01.
REQ-017 IR is 5 bits.
- Capture-IR SHALL load 5'b00001.
- Shift-IR SHALL shift right with TDI entering at MSB.
- Update-IR SHALL commit the shift register to IR.
REQ-018 DR select by IR value:
- 0x01: IDCODE, 32 bits.
- 0x10: DTMCS, 32 bits.
- 0x11: DMI, DMI_ABITS+34 bits.
- 0x1f and all other codes: BYPASS, 1 bit capturing 0.
REQ-019 DTMCS capture value SHALL be {14'b0, 2'b00, 1'b0, 3'd1, dmistat[1:0], DMI_ABITS[5:0], 4'd1}.
REQ-020 DMI capture SHALL load {last_addr, last_rdata, status}.
- status = 2'b11 if the sticky busy flag is set or a request is pending; otherwise 2'b00.
REQ-021 Shift-DR SHALL shift right: TDI enters the MSB of the selected DR and the LSB leaves toward TDO.
REQ-022 jtag_tdo SHALL update on the TCK fall strobe to the shift-register LSB while in ShIR or ShDR. It SHALL be 0 in all other states.
REQ-023 Update-DR on DMI with op=1 (read) or op=2 (write), no pending request and sticky busy clear:
- SHALL latch the DR into dmi_req_data.
- SHALL assert dmi_req_valid.
- SHALL record addr into last_addr.
REQ-024 dmi_req_valid SHALL hold until the clk cycle where dmi_req_ready=1, then deassert the next cycle. dmi_req_data SHALL be stable while valid.
REQ-025 Update-DR on DMI with op!=0 while a request is pending SHALL set sticky busy (dmistat=3) and issue nothing. op=0 SHALL be a no-op.
REQ-026 When dmi_resp_valid=1, last_rdata SHALL load dmi_resp_data and the pending flag SHALL clear.
- A request is pending from issue until dmi_resp_valid.
- Response and a new Update-DR in the same cycle: the response is applied first.
REQ-027 Update-DR on DTMCS:
- Bit16 (dmireset) SHALL clear sticky busy.
- Bit17 (dmihardreset) SHALL clear sticky busy, the pending flag and dmi_req_valid.
- Other bits are ignored.
REQ-028 Update-DR on IDCODE or BYPASS SHALL have no side effect.

Reset
REQ-029 rst=0 SHALL asynchronously set:
- TAP FSM to TLR, IR to 5'h01, all shift registers to 0.
- jtag_tdo to 0, dmi_req_valid to 0, dmi_req_data to 0.
- last_addr, last_rdata, pending and sticky busy to 0.
REQ-030 Assertion of rst mid-scan or mid-request SHALL abort the scan and drop the request. No partial update SHALL occur after release.
REQ-031 TLR entered via TMS SHALL reset only IR and the FSM. DMI state is kept.

Verification
REQ-032 rst pulse, then 8 TCK with TMS=1 -> IR=0x01, jtag_tdo=0, dmi_req_valid=0.
REQ-033 32-bit DR scan in IDCODE -> bits shifted out equal 32'h1e200a6d, LSB first.
REQ-034 Scan IR 0x11, then DMI DR {6'h10, 32'h0, 2'b10} -> dmi_req_valid=1 with dmi_req_data=40'h40_0000_0002.
- Holding dmi_req_ready=0 for 5 clk keeps valid and data stable.
- Ready=1 -> valid=0 next cycle.
REQ-035 Send read {6'h11, 0, 2'b01}, respond with dmi_resp_data=32'h0040_0c82, then send op=0 scan -> shifted-out value = {6'h11, 32'h0040_0c82, 2'b00}.
REQ-036 Second DMI write while the first is pending -> no new request; next DMI capture status=3 and DTMCS dmistat=3. DTMCS write with bit16=1 -> status returns to 0.
REQ-037 rst=0 asserted during ShDR at bit 20 of 40 -> FSM in TLR, no dmi_req_valid after release, IR=0x01.

Source files
------------

// File: rtl/jtag_dtm_tap.sv
// rtl/jtag_dtm_tap.sv - JTAG debug transport module: TCK-oversampled TAP controller driving a DMI request port
module jtag_dtm_tap #(
  parameter logic [31:0] IDCODE    = 32'h1e200a6d,
  parameter int          DMI_ABITS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jtag_tck,
  input  logic                   jtag_tms,
  input  logic                   jtag_tdi,
  output logic                   jtag_tdo,
  output logic                   dmi_req_valid,
  input  logic                   dmi_req_ready,
  output logic [DMI_ABITS+33:0]  dmi_req_data,
  input  logic                   dmi_resp_valid,
  input  logic [31:0]            dmi_resp_data
);

  localparam int         DW        = DMI_ABITS + 34;
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [5:0] ABITS6    = 6'(DMI_ABITS);

  typedef enum logic [3:0] {
    S_EX2_DR = 4'h0, S_EX1_DR = 4'h1, S_SH_DR  = 4'h2, S_PAU_DR = 4'h3,
    S_SEL_IR = 4'h4, S_UPD_DR = 4'h5, S_CAP_DR = 4'h6, S_SEL_DR = 4'h7,
    S_EX2_IR = 4'h8, S_EX1_IR = 4'h9, S_SH_IR  = 4'hA, S_PAU_IR = 4'hB,
    S_RTI    = 4'hC, S_UPD_IR = 4'hD, S_CAP_IR = 4'hE, S_TLR    = 4'hF
  } tap_state_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      S_TLR:    return tms ? S_TLR    : S_RTI;
      S_RTI:    return tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: return tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: return tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  return tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: return tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: return tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: return tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: return tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: return tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: return tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  return tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: return tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: return tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: return tms ? S_UPD_IR : S_SH_IR;
      default:  return tms ? S_SEL_DR : S_RTI;
    endcase
  endfunction

  logic [1:0]    tck_sync_q, tms_sync_q, tdi_sync_q;
  logic          tck_prev_q, tck_rise_q, tck_fall_q;
  tap_state_e    state_q;
  logic [4:0]    ir_q, ir_sr_q;
  logic [DW-1:0] dr_sr_q;
  logic [DMI_ABITS-1:0] last_addr_q;
  logic [31:0]   last_rdata_q;
  logic          pending_q, busy_q;

  logic          tms_s, tdi_s;
  logic [1:0]    dmi_status;
  logic [31:0]   dtmcs_cap;
  logic [DW-1:0] dr_capture, dr_shift;
  logic          dmi_upd, dtmcs_upd, pending_now;
  logic [1:0]    dr_op;

  assign tms_s       = tms_sync_q[1];
  assign tdi_s       = tdi_sync_q[1];
  assign dmi_status  = (busy_q || pending_q) ? 2'b11 : 2'b00;
  assign dtmcs_cap   = {14'b0, 2'b00, 1'b0, 3'd1, dmi_status, ABITS6, 4'd1};
  assign dr_op       = dr_sr_q[1:0];
  assign dmi_upd     = tck_fall_q && (state_q == S_UPD_DR) && (ir_q == IR_DMI);
  assign dtmcs_upd   = tck_fall_q && (state_q == S_UPD_DR) && (ir_q == IR_DTMCS);
  assign pending_now = pending_q && !dmi_resp_valid;

  always_comb begin
    dr_capture = '0;
    dr_shift   = dr_sr_q >> 1;
    case (ir_q)
      IR_IDCODE: begin dr_capture[31:0] = IDCODE;    dr_shift[31] = tdi_s; end
      IR_DTMCS:  begin dr_capture[31:0] = dtmcs_cap; dr_shift[31] = tdi_s; end
      IR_DMI: begin
        dr_capture     = {last_addr_q, last_rdata_q, dmi_status};
        dr_shift[DW-1] = tdi_s;
      end
      default:   dr_shift = {{(DW-1){1'b0}}, tdi_s};
    endcase
  end

  // TCK is oversampled: the registered edge strobes are the only TAP timing reference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_prev_q <= 1'b0;
      tck_rise_q <= 1'b0;
      tck_fall_q <= 1'b0;
    end else begin
      tck_sync_q <= {tck_sync_q[0], jtag_tck};
      tms_sync_q <= {tms_sync_q[0], jtag_tms};
      tdi_sync_q <= {tdi_sync_q[0], jtag_tdi};
      tck_prev_q <= tck_sync_q[1];
      tck_rise_q <= tck_sync_q[1] & ~tck_prev_q;
      tck_fall_q <= ~tck_sync_q[1] & tck_prev_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_TLR;
      ir_q     <= IR_IDCODE;
      ir_sr_q  <= '0;
      dr_sr_q  <= '0;
      jtag_tdo <= 1'b0;
    end else begin
      if (tck_rise_q) begin
        case (state_q)
          S_CAP_IR: ir_sr_q <= 5'b00001;
          S_SH_IR:  ir_sr_q <= {tdi_s, ir_sr_q[4:1]};
          S_CAP_DR: dr_sr_q <= dr_capture;
          S_SH_DR:  dr_sr_q <= dr_shift;
          default:  ;
        endcase
        state_q <= tap_next(state_q, tms_s);
      end
      if (tck_fall_q) begin
        jtag_tdo <= (state_q == S_SH_IR) ? ir_sr_q[0] :
                    (state_q == S_SH_DR) ? dr_sr_q[0] : 1'b0;
        if (state_q == S_UPD_IR) ir_q <= ir_sr_q;
      end
      if (state_q == S_TLR) ir_q <= IR_IDCODE;
    end
  end

  // A response landing with an Update-DR is retired first, so it does not count as a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmi_req_valid <= 1'b0;
      dmi_req_data  <= '0;
      last_addr_q   <= '0;
      last_rdata_q  <= '0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if (dmi_resp_valid) begin
        last_rdata_q <= dmi_resp_data;
        pending_q    <= 1'b0;
      end
      if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
      if (dmi_upd && dr_op != 2'b00) begin
        if (pending_now) begin
          busy_q <= 1'b1;
        end else if (!busy_q && dr_op != 2'b11) begin
          dmi_req_valid <= 1'b1;
          dmi_req_data  <= dr_sr_q;
          pending_q     <= 1'b1;
          last_addr_q   <= dr_sr_q[DW-1:34];
        end
      end
      if (dtmcs_upd) begin
        if (dr_sr_q[16] || dr_sr_q[17]) busy_q <= 1'b0;
        if (dr_sr_q[17]) begin
          pending_q     <= 1'b0;
          dmi_req_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// tb/tb_jtag_dtm_tap.sv - directed bench for jtag_dtm_tap
module tb_jtag_dtm_tap;

  logic        clk = 1'b0;
  logic        rst;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
  logic        dmi_req_valid, dmi_req_ready;
  logic [39:0] dmi_req_data;
  logic        dmi_resp_valid;
  logic [31:0] dmi_resp_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [39:0] dout;

  always #5 clk = ~clk;

  jtag_dtm_tap #(.IDCODE(32'h1e200a6d), .DMI_ABITS(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .jtag_tck       (jtag_tck),
    .jtag_tms       (jtag_tms),
    .jtag_tdi       (jtag_tdi),
    .jtag_tdo       (jtag_tdo),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_data   (dmi_req_data),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_data  (dmi_resp_data)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pulse(input logic tms, input logic tdi);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (2) @(negedge clk);
    jtag_tck = 1'b1;
    repeat (8) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic scan_ir(input logic [4:0] v);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pulse(i == 4, v[i]);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input logic [39:0] din, input int n, output logic [39:0] q);
    q = '0;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      q[i] = jtag_tdo;
      pulse(i == n - 1, din[i]);
    end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
  endtask

  task automatic accept();
    dmi_req_ready = 1'b1;
    @(negedge clk);
    dmi_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    dmi_resp_valid = 1'b1;
    dmi_resp_data  = d;
    @(negedge clk);
    dmi_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0;
    dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = '0;
    repeat (5) @(negedge clk);
    check("rst_tdo", {39'b0, jtag_tdo}, 40'h0);
    check("rst_valid", {39'b0, dmi_req_valid}, 40'h0);
    check("rst_data", dmi_req_data, 40'h0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
    check("tlr_tdo", {39'b0, jtag_tdo}, 40'h0);
    check("tlr_valid", {39'b0, dmi_req_valid}, 40'h0);
    pulse(1'b0, 1'b0);
    scan_dr(40'h0, 32, dout);
    check("idcode", dout, 40'h00_1e20_0a6d);

    scan_ir(5'h1f);
    scan_dr(40'hA5, 8, dout);
    check("bypass", dout, 40'h4A);

    scan_ir(5'h10);
    scan_dr(40'h0, 32, dout);
    check("dtmcs_idle", dout, 40'h1061);

    scan_ir(5'h11);
    scan_dr({6'h10, 32'h0, 2'b10}, 40, dout);
    check("wr_valid", {39'b0, dmi_req_valid}, 40'h1);
    check("wr_data", dmi_req_data, 40'h40_0000_0002);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {39'b0, dmi_req_valid}, 40'h1);
      check("hold_data", dmi_req_data, 40'h40_0000_0002);
    end
    accept();
    check("wr_ack_valid", {39'b0, dmi_req_valid}, 40'h0);
    respond(32'h0);

    scan_dr({6'h11, 32'h0, 2'b01}, 40, dout);
    check("rd_data", dmi_req_data, 40'h44_0000_0001);
    accept();
    respond(32'h0040_0c82);
    scan_dr(40'h0, 40, dout);
    check("rd_result", dout, 40'h44_0100_3208);
    check("nop_valid", {39'b0, dmi_req_valid}, 40'h0);

    scan_dr({6'h05, 32'hdeadbeef, 2'b10}, 40, dout);
    check("wr2_valid", {39'b0, dmi_req_valid}, 40'h1);
    accept();
    scan_dr({6'h06, 32'h1, 2'b10}, 40, dout);
    check("busy_no_req", {39'b0, dmi_req_valid}, 40'h0);
    scan_dr(40'h0, 40, dout);
    check("busy_dmi_cap", dout, 40'h14_0100_320B);
    scan_ir(5'h10);
    scan_dr(40'h0, 32, dout);
    check("busy_dtmcs", dout, 40'h1C61);
    respond(32'h1234_5678);
    scan_dr(40'h0, 32, dout);
    check("busy_sticky", dout, 40'h1C61);
    scan_dr(40'h0001_0000, 32, dout);
    scan_dr(40'h0, 32, dout);
    check("dmireset", dout, 40'h1061);
    scan_ir(5'h11);
    scan_dr(40'h0, 40, dout);
    check("dmi_cap_clr", dout, 40'h14_48D1_59E0);

    scan_dr({6'h07, 32'h0, 2'b10}, 40, dout);
    check("wr3_valid", {39'b0, dmi_req_valid}, 40'h1);
    scan_ir(5'h10);
    scan_dr(40'h0002_0000, 32, dout);
    check("hard_pending", dout, 40'h1C61);
    check("hard_valid", {39'b0, dmi_req_valid}, 40'h0);
    scan_dr(40'h0, 32, dout);
    check("hard_dtmcs", dout, 40'h1061);

    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    scan_ir(5'h11);
    scan_dr(40'h0, 40, dout);
    check("tms_tlr_keep", dout, 40'h1C_48D1_59E0);

    dout = {6'h10, 32'h0, 2'b10};
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) pulse(1'b0, dout[i]);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_tdo", {39'b0, jtag_tdo}, 40'h0);
    check("midrst_valid", {39'b0, dmi_req_valid}, 40'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_valid", {39'b0, dmi_req_valid}, 40'h0);
    pulse(1'b0, 1'b0);
    scan_dr(40'h0, 32, dout);
    check("post_rst_idcode", dout, 40'h00_1e20_0a6d);
    scan_ir(5'h11);
    scan_dr(40'h0, 40, dout);
    check("post_rst_dmi", dout, 40'h0);
    check("post_rst_noreq", {39'b0, dmi_req_valid}, 40'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
